hazard_stall_unit: RTL and testbench

- Companion to the operand-forwarding logic in the 5-stage pipeline: forwarding resolves EX/MEM and MEM/WB results, and this block stalls issue when a result is not yet forwardable.
- Sits at the ID stage and keeps a per-register scoreboard of in-flight writers: ALU, load, and the multi-cycle multiplier.
- Drives the PC/IF-ID hold and ID/EX bubble controls.
- Provides a saturating stall counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/hazard_stall_unit_if.sv | 24 ++
 rtl/sb_counter.sv | 14 +
 rtl/hazard_stall_unit.sv | 70 +++++++
 tb/tb_hazard_stall_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared instruction-class encodings and pipeline constants
package pipe_pkg;
    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_LOAD = 2'b01,
        CLS_MUL  = 2'b10,
        CLS_RSV  = 2'b11
    } instr_cls_e;
    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT_DEF = 4;
    localparam int REG_W = 5;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: ID-stage issue request and stall/debug response bundle
interface hazard_stall_unit_if #(parameter int PERF_W = 16);
    import pipe_pkg::*;
    logic id_valid;
    logic [REG_W-1:0] id_rsA;
    logic [REG_W-1:0] id_rsB;
    logic id_rsA_used;
    logic id_rsB_used;
    logic [REG_W-1:0] id_rd;
    logic id_RegWrite;
    logic [1:0] id_class;
    logic stall;
    logic bubble;
    logic [31:0] pending_mask;
    logic [PERF_W-1:0] stall_count;
    modport master(
        output id_valid, id_rsA, id_rsB, id_rsA_used, id_rsB_used, id_rd, id_RegWrite, id_class,
        input stall, bubble, pending_mask, stall_count
    );
    modport slave(
        input id_valid, id_rsA, id_rsB, id_rsA_used, id_rsB_used, id_rd, id_RegWrite, id_class,
        output stall, bubble, pending_mask, stall_count
    );
endinterface

// File: rtl/sb_counter.sv
// sb_counter: countdown that stops at zero, with load taking priority over decrement
module sb_counter #(parameter int W = 3) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic [W-1:0] cnt
);
    // load wins; otherwise count down toward zero and stay there
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (load) cnt <= val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage scoreboard that stalls issue until operands are forwardable
module hazard_stall_unit import pipe_pkg::*; #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W = 3,
    parameter int PERF_W = 16
) (
    input logic clk,
    input logic rst,
    hazard_stall_unit_if.slave bus
);
    logic [CNT_W-1:0] cnt [32];
    logic [CNT_W-1:0] mul_busy;
    logic [CNT_W-1:0] issue_lat;
    logic [PERF_W-1:0] count;
    logic [31:0] pm;
    logic raw_a, raw_b, waw, mulb, stall, issue, is_mul;

    function automatic logic [CNT_W-1:0] lat(input logic [1:0] c);
        return c == CLS_LOAD ? CNT_W'(LOAD_LAT) : c == CLS_MUL ? CNT_W'(MUL_LAT - 1) : '0;
    endfunction

    assign cnt[0] = '0;
    assign is_mul = bus.id_class == CLS_MUL;
    assign issue_lat = lat(bus.id_class);

    // hazard detection; reset masks any stale scoreboard state
    always_comb begin
        raw_a = bus.id_rsA_used && bus.id_rsA != '0 && cnt[bus.id_rsA] != '0;
        raw_b = bus.id_rsB_used && bus.id_rsB != '0 && cnt[bus.id_rsB] != '0;
        waw = bus.id_RegWrite && bus.id_rd != '0 && cnt[bus.id_rd] > issue_lat;
        mulb = is_mul && mul_busy != '0;
        stall = !rst && bus.id_valid && (raw_a || raw_b || waw || mulb);
        issue = !rst && bus.id_valid && !stall;
    end

    genvar i;
    for (i = 1; i < 32; i++) begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
            .clk(clk),
            .rst(rst),
            .load(issue && bus.id_RegWrite && bus.id_rd == REG_W'(i)),
            .val(issue_lat),
            .cnt(cnt[i])
        );
    end

    sb_counter #(.W(CNT_W)) u_mul (
        .clk(clk),
        .rst(rst),
        .load(issue && is_mul),
        .val(CNT_W'(MUL_LAT - 1)),
        .cnt(mul_busy)
    );

    // debug view of which registers still have an outstanding writer
    always_comb begin
        pm = '0;
        for (int r = 1; r < 32; r++) pm[r] = !rst && cnt[r] != '0;
    end

    // saturating performance counter of stall cycles
    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (stall && !(&count)) count <= count + 1'b1;

    assign bus.stall = stall;
    assign bus.bubble = stall;
    assign bus.pending_mask = pm;
    assign bus.stall_count = count;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: randomized and directed checks against a timestamp-based hazard model
module tb_hazard_stall_unit;
    localparam int MUL_LAT = 4;
    localparam int PERF_W = 5;
    localparam int SC_MAX = (1 << PERF_W) - 1;

    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int errors = 0;

    int now = 0;
    int ready [32];
    int mul_ready = 0;
    int sc = 0;

    hazard_stall_unit_if #(.PERF_W(PERF_W)) bus();

    hazard_stall_unit #(.MUL_LAT(MUL_LAT), .CNT_W(3), .PERF_W(PERF_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at cycle %0d", name, act, exp, now);
        end
    endtask

    function automatic int lat(input logic [1:0] c);
        return c == 2'b01 ? 1 : c == 2'b10 ? MUL_LAT - 1 : 0;
    endfunction

    // a register becomes readable at cycle ready[r]; its remaining wait is ready[r]-now
    function automatic bit m_stall();
        bit ra, rb, ww, mb;
        if (rst || !bus.id_valid) return 0;
        ra = bus.id_rsA_used && bus.id_rsA != 0 && now < ready[bus.id_rsA];
        rb = bus.id_rsB_used && bus.id_rsB != 0 && now < ready[bus.id_rsB];
        ww = bus.id_RegWrite && bus.id_rd != 0 && (ready[bus.id_rd] - now) > lat(bus.id_class);
        mb = bus.id_class == 2'b10 && now < mul_ready;
        return ra || rb || ww || mb;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) m[r] = !rst && now < ready[r];
        return m;
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) ready[r] = 0;
        forever begin
            bit s;
            @(posedge clk);
            s = m_stall();
            if (rst) begin
                for (int r = 0; r < 32; r++) ready[r] = 0;
                mul_ready = 0;
                sc = 0;
            end else begin
                if (s && sc < SC_MAX) sc++;
                if (bus.id_valid && !s) begin
                    if (bus.id_RegWrite && bus.id_rd != 0) ready[bus.id_rd] = now + 1 + lat(bus.id_class);
                    if (bus.id_class == 2'b10) mul_ready = now + MUL_LAT;
                end
            end
            now++;
        end
    end

    initial forever begin
        bit s;
        @(negedge clk);
        s = m_stall();
        chk("stall", int'(bus.stall), int'(s));
        chk("bubble", int'(bus.bubble), int'(s));
        chk("pending_mask", int'(bus.pending_mask), int'(m_mask()));
        chk("stall_count", int'(bus.stall_count), sc);
    end

    task automatic set_in(input logic [1:0] c, input int rd, input int we, input int a, input int au,
                          input int b, input int bu);
        bus.id_valid = 1;
        bus.id_class = c;
        bus.id_rd = 5'(rd);
        bus.id_RegWrite = we[0];
        bus.id_rsA = 5'(a);
        bus.id_rsA_used = au[0];
        bus.id_rsB = 5'(b);
        bus.id_rsB_used = bu[0];
    endtask

    task automatic hold(input logic [1:0] c, input int rd, input int we, input int a, input int au,
                        input int b, input int bu, output int n);
        set_in(c, rd, we, a, au, b, bu);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (!bus.stall) begin
                @(posedge clk);
                #1;
                return;
            end
            n++;
            @(posedge clk);
            #1;
        end
        chk("hold_timeout", n, -1);
    endtask

    task automatic idle(input int k);
        bus.id_valid = 0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        bus.id_valid = 0;
        bus.id_class = 0;
        bus.id_rd = 0;
        bus.id_RegWrite = 0;
        bus.id_rsA = 0;
        bus.id_rsA_used = 0;
        bus.id_rsB = 0;
        bus.id_rsB_used = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall_count", int'(bus.stall_count), 0);
        chk("reset_mask", int'(bus.pending_mask), 0);
        rst = 0;

        hold(2'b01, 5, 1, 0, 0, 0, 0, n);
        chk("load_issue", n, 0);
        hold(2'b00, 6, 1, 5, 1, 0, 0, n);
        chk("load_use_stalls", n, 1);
        #2 chk("load_use_count", int'(bus.stall_count), 1);
        idle(3);

        hold(2'b00, 3, 1, 0, 0, 0, 0, n);
        hold(2'b00, 4, 1, 1, 1, 3, 1, n);
        chk("alu_chain_stalls", n, 0);
        chk("alu_chain_mask", int'(bus.pending_mask), 0);
        idle(3);

        hold(2'b10, 7, 1, 0, 0, 0, 0, n);
        #1 chk("mul_mask7", int'(bus.pending_mask[7]), 1);
        hold(2'b00, 8, 1, 7, 1, 0, 0, n);
        chk("mul_dep_stalls", n, 3);
        idle(5);
        hold(2'b10, 10, 1, 0, 0, 0, 0, n);
        hold(2'b10, 11, 1, 0, 0, 0, 0, n);
        chk("mul_busy_stalls", n, 3);
        idle(5);

        hold(2'b10, 9, 1, 0, 0, 0, 0, n);
        hold(2'b00, 9, 1, 0, 0, 0, 0, n);
        chk("waw_stalls", n, 3);
        #1 chk("waw_mask9", int'(bus.pending_mask[9]), 0);
        idle(3);

        hold(2'b01, 0, 1, 0, 0, 0, 0, n);
        hold(2'b00, 1, 1, 0, 1, 0, 1, n);
        chk("r0_stalls", n, 0);
        hold(2'b01, 4, 1, 0, 0, 0, 0, n);
        hold(2'b00, 1, 1, 4, 0, 0, 0, n);
        chk("unused_src_stalls", n, 0);
        idle(3);

        hold(2'b01, 12, 1, 0, 0, 0, 0, n);
        hold(2'b00, 13, 1, 12, 1, 12, 1, n);
        chk("same_src_stalls", n, 1);
        idle(3);

        hold(2'b10, 2, 1, 0, 0, 0, 0, n);
        bus.id_valid = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        set_in(2'b00, 3, 1, 2, 1, 0, 0);
        #2;
        chk("rst_mid_stall", int'(bus.stall), 0);
        chk("rst_mid_mask", int'(bus.pending_mask), 0);
        chk("rst_mid_count", int'(bus.stall_count), 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(0, 299) == 0;
            bus.id_valid = $urandom_range(0, 3) != 0;
            bus.id_class = 2'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom_range(0, 7));
            bus.id_RegWrite = 1'($urandom_range(0, 1));
            bus.id_rsA = 5'($urandom_range(0, 7));
            bus.id_rsA_used = 1'($urandom_range(0, 1));
            bus.id_rsB = 5'($urandom_range(0, 7));
            bus.id_rsB_used = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rst = 0;
        idle(2);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
